// File: rtl/running_acc_win.sv
// running_acc_win: running sum of unsigned samples, either cumulative
// (mod 2^SUM_W with a sticky carry-out flag) or over a sliding window of
// the last DEPTH accepted samples. The operating mode is captured only while
// reset or clear is high, so a window never mixes the two accumulation rules.
module running_acc_win #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          idata,
  input  logic                       mode,
  input  logic                       clear,
  output logic [SUM_W-1:0]           odata,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       ovf
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reject parameter sets where the window sum could wrap or the buffer is illegal.
  if ((DEPTH < 2) || (DEPTH > 256)) begin : g_bad_depth
    $error("running_acc_win: DEPTH must be within 2..256");
  end
  if (SUM_W < (DATA_W + $clog2(DEPTH))) begin : g_bad_sum_w
    $error("running_acc_win: SUM_W too narrow for DATA_W and DEPTH");
  end

  logic [SUM_W-1:0]  odata_q,     odata_d;
  logic              out_valid_q, out_valid_d;
  logic [FILL_W-1:0] fill_q,      fill_d;
  logic              ovf_q,       ovf_d;
  logic              mode_q,      mode_d;
  logic [PTR_W-1:0]  wptr_q,      wptr_d;

  // Sample history; no reset needed because fill gates every read of it.
  logic [DATA_W-1:0] win_mem [DEPTH];

  logic              wr_en_s;
  logic              full_s;
  logic [DATA_W-1:0] oldest_s;
  logic [SUM_W:0]    cum_sum_s;
  logic [SUM_W-1:0]  win_sum_s;
  logic [PTR_W-1:0]  wptr_nxt_s;

  // Datapath helpers: cumulative sum with carry, window sum, pointer wrap.
  always_comb begin
    full_s     = (fill_q == FILL_W'(DEPTH));
    // When full, the write pointer sits on the oldest sample, the one about to be replaced.
    oldest_s   = win_mem[wptr_q];
    cum_sum_s  = {1'b0, odata_q} + (SUM_W + 1)'(idata);
    if (full_s) begin
      win_sum_s = odata_q + SUM_W'(idata) - SUM_W'(oldest_s);
    end else begin
      win_sum_s = odata_q + SUM_W'(idata);
    end
    if (wptr_q == PTR_W'(DEPTH - 1)) begin
      wptr_nxt_s = PTR_W'(0);
    end else begin
      wptr_nxt_s = wptr_q + PTR_W'(1);
    end
  end

  // Next-state: clear restarts everything, otherwise an accepted sample updates the sum.
  always_comb begin
    odata_d     = odata_q;
    out_valid_d = 1'b0;
    fill_d      = fill_q;
    ovf_d       = ovf_q;
    mode_d      = mode_q;
    wptr_d      = wptr_q;
    wr_en_s     = 1'b0;
    if (clear) begin
      mode_d  = mode;
      odata_d = SUM_W'(0);
      fill_d  = FILL_W'(0);
      ovf_d   = 1'b0;
      wptr_d  = PTR_W'(0);
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      if (mode_q) begin
        wr_en_s = 1'b1;
        wptr_d  = wptr_nxt_s;
        odata_d = win_sum_s;
        if (full_s) begin
          fill_d = fill_q;
        end else begin
          fill_d = fill_q + FILL_W'(1);
        end
      end else begin
        odata_d = cum_sum_s[SUM_W-1:0];
        if (cum_sum_s[SUM_W]) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; mode is captured during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      odata_q     <= SUM_W'(0);
      out_valid_q <= 1'b0;
      fill_q      <= FILL_W'(0);
      ovf_q       <= 1'b0;
      mode_q      <= mode;
      wptr_q      <= PTR_W'(0);
    end else begin
      odata_q     <= odata_d;
      out_valid_q <= out_valid_d;
      fill_q      <= fill_d;
      ovf_q       <= ovf_d;
      mode_q      <= mode_d;
      wptr_q      <= wptr_d;
    end
  end

  // Window buffer write at the current write pointer.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      win_mem[wptr_q] <= idata;
    end
  end

  assign odata     = odata_q;
  assign out_valid = out_valid_q;
  assign fill      = fill_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_running_acc_win.sv
// Bench for running_acc_win: three instances share one stimulus stream
// (defaults; DEPTH=4; DATA_W=8/SUM_W=9/DEPTH=2). A history-based model
// predicts every output each cycle; directed literal checks pin the model.
module tb_running_acc_win;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] idata = 8'd0;
  logic       mode = 1'b0;
  logic       clear = 1'b0;

  logic [31:0] od0, od1;
  logic [8:0]  od2;
  logic [3:0]  fl0;
  logic [2:0]  fl1;
  logic [1:0]  fl2;
  logic        ov0, ov1, ov2;
  logic        of0, of1, of2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  running_acc_win #(.DATA_W(8), .SUM_W(32), .DEPTH(8)) u_d0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .idata(idata), .mode(mode),
    .clear(clear), .odata(od0), .out_valid(ov0), .fill(fl0), .ovf(of0));
  running_acc_win #(.DATA_W(8), .SUM_W(32), .DEPTH(4)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .idata(idata), .mode(mode),
    .clear(clear), .odata(od1), .out_valid(ov1), .fill(fl1), .ovf(of1));
  running_acc_win #(.DATA_W(8), .SUM_W(9), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .idata(idata), .mode(mode),
    .clear(clear), .odata(od2), .out_valid(ov2), .fill(fl2), .ovf(of2));

  // Model: the list of samples accepted since the last reset/clear and the latched mode.
  int  hist [0:1023];
  int  hlen = 0;
  bit  mode_m = 1'b0;
  bit  outv_m = 1'b0;
  bit  model_ok = 1'b0;

  function automatic int dep_of(input int k);
    case (k)
      0:       return 8;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int sw_of(input int k);
    case (k)
      0:       return 32;
      1:       return 32;
      default: return 9;
    endcase
  endfunction

  function automatic longint total_all();
    longint t = 0;
    for (int i = 0; i < hlen; i++) t += hist[i];
    return t;
  endfunction

  function automatic longint exp_od(input int k);
    longint t = 0;
    int n;
    if (mode_m) n = (hlen < dep_of(k)) ? hlen : dep_of(k);
    else        n = hlen;
    for (int i = hlen - n; i < hlen; i++) t += hist[i];
    return t % (64'sd1 << sw_of(k));
  endfunction

  function automatic longint exp_fill(input int k);
    if (!mode_m) return 0;
    return (hlen < dep_of(k)) ? hlen : dep_of(k);
  endfunction

  function automatic longint exp_ovf(input int k);
    if (mode_m) return 0;
    return (total_all() >= (64'sd1 << sw_of(k))) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (reset || clear) begin
      mode_m   <= mode;
      hlen     <= 0;
      outv_m   <= 1'b0;
      model_ok <= 1'b1;
    end else if (in_valid) begin
      hist[hlen] <= int'(idata);
      hlen       <= hlen + 1;
      outv_m     <= 1'b1;
    end else begin
      outv_m <= 1'b0;
    end
  end

  // Per-cycle comparison of all instances against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("odata0", {32'd0, od0}, exp_od(0));
      chk("fill0",  {60'd0, fl0}, exp_fill(0));
      chk("ovf0",   {63'd0, of0}, exp_ovf(0));
      chk("oval0",  {63'd0, ov0}, {63'd0, outv_m});
      chk("odata1", {32'd0, od1}, exp_od(1));
      chk("fill1",  {61'd0, fl1}, exp_fill(1));
      chk("ovf1",   {63'd0, of1}, exp_ovf(1));
      chk("oval1",  {63'd0, ov1}, {63'd0, outv_m});
      chk("odata2", {55'd0, od2}, exp_od(2));
      chk("fill2",  {62'd0, fl2}, exp_fill(2));
      chk("ovf2",   {63'd0, of2}, exp_ovf(2));
      chk("oval2",  {63'd0, ov2}, {63'd0, outv_m});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] v);
    in_valid = 1'b1;
    idata    = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input logic m, input int n);
    reset = 1'b1;
    mode  = m;
    repeat (n) step();
    reset = 1'b0;
  endtask

  int exp_w4_od [6] = '{10, 30, 60, 100, 140, 180};
  int exp_w4_fl [6] = '{1, 2, 3, 4, 4, 4};
  int exp_ovf_od [3] = '{255, 510, 253};
  int exp_ovf_f  [3] = '{0, 0, 1};
  int pulses;

  initial begin
    // Cumulative 1..10 on default parameters.
    do_reset(1'b0, 10);
    chk("rst_odata", {32'd0, od0}, 64'd0);
    chk("rst_fill",  {60'd0, fl0}, 64'd0);
    chk("rst_oval",  {63'd0, ov0}, 64'd0);
    chk("rst_ovf",   {63'd0, of0}, 64'd0);
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      feed(8'(i));
      chk("cum_odata", {32'd0, od0}, 64'(i * (i + 1) / 2));
      if (ov0) pulses++;
    end
    step();
    if (ov0) pulses++;
    chk("cum_pulses", 64'(pulses), 64'd10);
    chk("cum_ovf", {63'd0, of0}, 64'd0);

    // Cumulative overflow on the 9-bit accumulator.
    do_reset(1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      feed(8'd255);
      chk("ovf_odata", {55'd0, od2}, 64'(exp_ovf_od[i]));
      chk("ovf_flag",  {63'd0, of2}, 64'(exp_ovf_f[i]));
    end
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ovf_sticky", {63'd0, of2}, 64'd1);
      chk("ovf_hold",   {55'd0, od2}, 64'd253);
    end

    // Windowed mode, DEPTH=4 instance.
    do_reset(1'b1, 1);
    for (int i = 0; i < 6; i++) begin
      feed(8'(10 * (i + 1)));
      chk("win_odata", {32'd0, od1}, 64'(exp_w4_od[i]));
      chk("win_fill",  {61'd0, fl1}, 64'(exp_w4_fl[i]));
    end
    chk("win_ovf", {63'd0, of1}, 64'd0);

    // Gaps in in_valid.
    do_reset(1'b0, 1);
    feed(8'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_odata", {32'd0, od0}, 64'd5);
      chk("gap_oval",  {63'd0, ov0}, 64'd0);
    end
    feed(8'd7);
    chk("gap_after", {32'd0, od0}, 64'd12);

    // Clear beats in_valid; a mode change outside reset/clear is ignored.
    do_reset(1'b0, 1);
    mode = 1'b1;
    feed(8'd100);
    chk("clr_pre",      {32'd0, od0}, 64'd100);
    chk("clr_pre_fill", {60'd0, fl0}, 64'd0);
    mode     = 1'b0;
    clear    = 1'b1;
    in_valid = 1'b1;
    idata    = 8'd99;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_odata", {32'd0, od0}, 64'd0);
    chk("clr_fill",  {60'd0, fl0}, 64'd0);
    chk("clr_oval",  {63'd0, ov0}, 64'd0);
    feed(8'd4);
    chk("clr_next", {32'd0, od0}, 64'd4);

    // Clear latching windowed mode.
    mode  = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    feed(8'd3);
    feed(8'd4);
    chk("clrw_odata", {32'd0, od1}, 64'd7);
    chk("clrw_fill",  {61'd0, fl1}, 64'd2);

    // Reset mid-window discards history, even with a sample presented.
    do_reset(1'b1, 1);
    for (int i = 1; i <= 5; i++) feed(8'(i));
    chk("mid_odata", {32'd0, od1}, 64'd14);
    chk("mid_fill",  {61'd0, fl1}, 64'd4);
    reset    = 1'b1;
    in_valid = 1'b1;
    idata    = 8'd77;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_odata", {32'd0, od1}, 64'd0);
    chk("mid_rst_oval",  {63'd0, ov1}, 64'd0);
    feed(8'd7);
    chk("mid_a_odata", {32'd0, od1}, 64'd7);
    chk("mid_a_fill",  {61'd0, fl1}, 64'd1);
    feed(8'd8);
    chk("mid_b_odata", {32'd0, od1}, 64'd15);
    chk("mid_b_fill",  {61'd0, fl1}, 64'd2);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/running_acc_win.md
RUNNING_ACC_WIN -- requirements
Module: running_acc_win

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning input sample width in bits (unsigned).
REQ-002 The block SHALL have parameter SUM_W, default 32, meaning accumulator/output width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning window length in samples, legal range 2..256.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning idata is accepted this cycle.
REQ-007 The block SHALL have port idata, input, DATA_W bits, meaning the sample value.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = cumulative sum, 1 = sliding-window sum.
REQ-009 The block SHALL have port clear, input, 1 bit, meaning synchronous restart of the sum.
REQ-010 The block SHALL have port odata, output, SUM_W bits, meaning the registered running sum.
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning odata was updated on the last edge.
REQ-012 The block SHALL have port fill, output, clog2(DEPTH+1) bits, meaning valid samples in the window.
REQ-013 The block SHALL have port ovf, output, 1 bit, meaning sticky cumulative-overflow flag.

Function
REQ-014 A sample SHALL be accepted on a rising edge where in_valid=1, reset=0 and clear=0.
REQ-015 odata SHALL reflect an accepted sample after that same edge; out_valid SHALL be 1 for exactly that following cycle and 0 otherwise.
REQ-016 With no accepted sample, odata, fill and ovf SHALL hold their values.
REQ-017 The active mode SHALL be latched only in cycles where reset or clear is 1; mode changes at other times SHALL be ignored.
REQ-018 Cumulative mode: odata SHALL become (odata + zero-extended idata) mod 2^SUM_W; fill SHALL remain 0.
REQ-019 Cumulative mode: ovf SHALL set on the edge where the addition carries out of SUM_W bits and SHALL stay set until reset or clear.
REQ-020 Windowed mode: every accepted sample SHALL be written to a DEPTH-entry circular buffer at the write pointer, which SHALL advance and wrap from DEPTH-1 to 0.
REQ-021 Windowed mode, fill<DEPTH: odata SHALL become odata + idata and fill SHALL increment by 1.
REQ-022 Windowed mode, fill=DEPTH: odata SHALL become odata + idata - oldest entry (the entry being overwritten), and fill SHALL saturate at DEPTH.
REQ-023 Buffer entries not written since the last reset/clear SHALL never contribute to odata.
REQ-024 ovf SHALL remain 0 in windowed mode.
REQ-025 The design SHALL fail elaboration if SUM_W < DATA_W + clog2(DEPTH) or DEPTH is outside 2..256.
REQ-026 clear SHALL have priority over in_valid: on an edge with clear=1, the sample SHALL be discarded and odata, fill, write pointer and ovf SHALL go to 0, with out_valid=0.

Reset
REQ-027 On an edge with reset=1, odata, out_valid, fill, ovf and the write pointer SHALL go to 0 and mode SHALL be latched; buffer contents need not be reset.
REQ-028 reset SHALL take priority over clear and in_valid; asserting it mid-window SHALL discard all window history.

Verification
REQ-029 Cumulative, defaults: reset 10 cycles, then feed 1..10 with in_valid=1 on consecutive cycles -> odata 1,3,6,...,55; 10 out_valid pulses; ovf=0.
REQ-030 Windowed, DEPTH=4: feed 10,20,30,40,50,60 -> odata 10,30,60,100,140,180; fill 1,2,3,4,4,4.
REQ-031 Cumulative, DATA_W=8, SUM_W=9: feed 255,255,255 -> odata 255,510,253; ovf rises after the third sample and stays 1 through 5 idle cycles.
REQ-032 in_valid gaps: feed 5, idle 3 cycles, feed 7 -> odata 5 held during the gap, then 12; out_valid 0 during the gap.
REQ-033 clear and in_valid=1 with idata=99 on the same edge after sum 100 -> odata 0, fill 0, out_valid 0; next sample 4 -> odata 4.
REQ-034 Windowed, DEPTH=4: feed 1,2,3,4,5, reset 1 cycle, then feed 7,8 -> odata 7,15 with fill 1,2, and no stale subtraction.
